// File: rtl/lighting_accumulate.sv
// Per-pixel diffuse light accumulator: sums light contributions onto an ambient term,
// saturates each channel and emits an 8-bit RGB pixel. Define LIGHTING_ACC_ROUND_EN for rounded conversion.
module lighting_accumulate #(
    parameter int MAX_LIGHTS = 8,
    parameter int FRAC_BITS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [95:0] diffuse_component,
    input  logic [95:0] ambient,
    input  logic        new_data,
    input  logic        last_light,
    output logic        in_ready,
    output logic [23:0] pixel_rgb,
    output logic        output_valid,
    input  logic        output_ready,
    output logic        overflow_err,
    output logic        count_err
);

    localparam int CW = $clog2(MAX_LIGHTS) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LIGHTS);
    localparam logic signed [31:0] ONE = 32'sd1 <<< FRAC_BITS;

    typedef enum logic [1:0] {IDLE, ACCUM, CONVERT, OUTPUT} state_t;

    state_t             state, state_next;
    logic signed [31:0] acc_r, acc_g, acc_b;
    logic signed [31:0] acc_r_next, acc_g_next, acc_b_next;
    logic [CW-1:0]      count, count_next;
    logic [23:0]        pixel_next;
    logic               valid_next, overflow_next, count_err_next;

    // Two's complement add with the 33-bit result clipped back into 32 bits.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        logic signed [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31])
            sat_add = s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        else
            sat_add = s[31:0];
    endfunction

    function automatic logic [7:0] to_byte(input logic signed [31:0] v);
        logic [39:0] w;
        logic [39:0] p;
        w = {8'd0, v};
        p = (w << 8) - w;
`ifdef LIGHTING_ACC_ROUND_EN
        p = p + (40'd1 << (FRAC_BITS - 1));
`endif
        p = p >> FRAC_BITS;
        if (v[31])
            to_byte = 8'd0;
        else if (v >= ONE)
            to_byte = 8'd255;
        else
            to_byte = p[7:0];
    endfunction

    assign in_ready = (state == IDLE) || (state == ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and datapath updates; inputs arriving outside IDLE/ACCUM only raise the drop flag.
    always_comb begin
        state_next     = state;
        acc_r_next     = acc_r;
        acc_g_next     = acc_g;
        acc_b_next     = acc_b;
        count_next     = count;
        pixel_next     = pixel_rgb;
        valid_next     = output_valid;
        overflow_next  = overflow_err | (new_data & ~in_ready);
        count_err_next = count_err;
        case (state)
            IDLE: begin
                if (new_data) begin
                    acc_r_next = sat_add($signed(ambient[95:64]), $signed(diffuse_component[95:64]));
                    acc_g_next = sat_add($signed(ambient[63:32]), $signed(diffuse_component[63:32]));
                    acc_b_next = sat_add($signed(ambient[31:0]),  $signed(diffuse_component[31:0]));
                    count_next = CW'(1);
                    if (last_light || (MAX_LIGHTS == 1)) begin
                        state_next = CONVERT;
                        if (!last_light)
                            count_err_next = 1'b1;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (new_data) begin
                    acc_r_next = sat_add(acc_r, $signed(diffuse_component[95:64]));
                    acc_g_next = sat_add(acc_g, $signed(diffuse_component[63:32]));
                    acc_b_next = sat_add(acc_b, $signed(diffuse_component[31:0]));
                    count_next = count + CW'(1);
                    if (last_light) begin
                        state_next = CONVERT;
                    end else if (count_next == MAX_CNT) begin
                        count_err_next = 1'b1;
                        state_next     = CONVERT;
                    end
                end
            end
            CONVERT: begin
                pixel_next = {to_byte(acc_r), to_byte(acc_g), to_byte(acc_b)};
                valid_next = 1'b1;
                state_next = OUTPUT;
            end
            OUTPUT: begin
                if (output_ready) begin
                    valid_next = 1'b0;
                    acc_r_next = '0;
                    acc_g_next = '0;
                    acc_b_next = '0;
                    count_next = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r        <= '0;
            acc_g        <= '0;
            acc_b        <= '0;
            count        <= '0;
            pixel_rgb    <= '0;
            output_valid <= 1'b0;
            overflow_err <= 1'b0;
            count_err    <= 1'b0;
        end else begin
            acc_r        <= acc_r_next;
            acc_g        <= acc_g_next;
            acc_b        <= acc_b_next;
            count        <= count_next;
            pixel_rgb    <= pixel_next;
            output_valid <= valid_next;
            overflow_err <= overflow_next;
            count_err    <= count_err_next;
        end
    end

endmodule

// File: tb/tb_lighting_accumulate.sv
// Randomised self-checking bench for lighting_accumulate against an arithmetic reference model.
module tb_lighting_accumulate;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] diffuse_component;
    logic [95:0] ambient;
    logic        new_data;
    logic        last_light;
    logic        in_ready;
    logic [23:0] pixel_rgb;
    logic        output_valid;
    logic        output_ready;
    logic        overflow_err;
    logic        count_err;

    int checks   = 0;
    int failures = 0;
    logic [95:0] dif_q[$];

`ifdef LIGHTING_ACC_ROUND_EN
    localparam longint RND = 32768;
    localparam logic [23:0] EXP_HALF = 24'h808080;
`else
    localparam longint RND = 0;
    localparam logic [23:0] EXP_HALF = 24'h7F7F7F;
`endif

    lighting_accumulate #(.MAX_LIGHTS(8), .FRAC_BITS(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .diffuse_component (diffuse_component),
        .ambient           (ambient),
        .new_data          (new_data),
        .last_light        (last_light),
        .in_ready          (in_ready),
        .pixel_rgb         (pixel_rgb),
        .output_valid      (output_valid),
        .output_ready      (output_ready),
        .overflow_err      (overflow_err),
        .count_err         (count_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic longint clamp32(input longint s);
        if (s > 64'sd2147483647)
            return 64'sd2147483647;
        if (s < -64'sd2147483648)
            return -64'sd2147483648;
        return s;
    endfunction

    function automatic longint chan(input logic [95:0] x, input int ch);
        logic [31:0] w;
        w = x[95 - 32*ch -: 32];
        return longint'($signed(w));
    endfunction

    function automatic logic [7:0] conv(input longint v);
        longint r;
        if (v < 0)
            return 8'd0;
        if (v >= 65536)
            return 8'd255;
        r = (v * 255 + RND) / 65536;
        return 8'(r);
    endfunction

    // Expected pixel: ambient plus every queued contribution, saturating after each add.
    function automatic logic [23:0] model_pixel(input logic [95:0] amb);
        logic [23:0] px;
        longint a;
        px = '0;
        for (int ch = 0; ch < 3; ch++) begin
            a = chan(amb, ch);
            foreach (dif_q[i])
                a = clamp32(a + chan(dif_q[i], ch));
            px[23 - 8*ch -: 8] = conv(a);
        end
        return px;
    endfunction

    function automatic logic [31:0] rnd_ch();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1, 2:    return $urandom_range(0, 32'h0000_6000);
            default: return -$urandom_range(0, 32'h0000_3000);
        endcase
    endfunction

    task automatic applyStimulus(input logic [95:0] amb, input logic [95:0] dif, input logic last);
        ambient           = amb;
        diffuse_component = dif;
        last_light        = last;
        new_data          = 1'b1;
        @(posedge clk); #1;
        new_data          = 1'b0;
        last_light        = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int c = 0; c < 20 && !output_valid; c++) begin
            @(posedge clk); #1;
        end
        if (!output_valid)
            checkOutput({tag, "_timeout"}, 32'(output_valid), 32'd1);
    endtask

    task automatic run_single(input string tag);
        output_ready = 1'b1;
        applyStimulus(96'd0, {3{32'h0000_8000}}, 1'b1);
        checkOutput({tag, "_valid_t0"}, 32'(output_valid), 32'd0);
        checkOutput({tag, "_inready_t0"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_valid_t1"}, 32'(output_valid), 32'd1);
        checkOutput({tag, "_pixel"}, 32'(pixel_rgb), 32'(EXP_HALF));
        @(posedge clk); #1;
        checkOutput({tag, "_valid_t2"}, 32'(output_valid), 32'd0);
        checkOutput({tag, "_inready_t2"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [95:0] amb;
        logic [95:0] dif;
        logic [23:0] exp_px;
        logic        last;
        int          n;

        rst = 1'b1; new_data = 1'b0; last_light = 1'b0; output_ready = 1'b0;
        ambient = '0; diffuse_component = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("reset_valid", 32'(output_valid), 32'd0);
        checkOutput("reset_pixel", 32'(pixel_rgb), 32'd0);
        checkOutput("reset_inready", 32'(in_ready), 32'd1);
        checkOutput("reset_flags", {30'd0, overflow_err, count_err}, 32'd0);

        run_single("single");

        output_ready = 1'b1;
        applyStimulus({32'h0000_1000, 64'd0}, {32'h0000_4000, 64'd0}, 1'b0);
        applyStimulus({32'h0000_1000, 64'd0}, {32'h0000_4000, 64'd0}, 1'b0);
        applyStimulus({32'h0000_1000, 64'd0}, {32'h0000_4000, 64'd0}, 1'b1);
        wait_valid("three");
        checkOutput("three_pixel", 32'(pixel_rgb), 32'h00CF_0000);
        @(posedge clk); #1;

        applyStimulus({32'h0000_C000, 32'h0, 32'h7FFF_FFF0}, {32'h0000_8000, 32'hFFFF_0000, 32'h0000_0100}, 1'b1);
        wait_valid("clamp");
        checkOutput("clamp_pixel", 32'(pixel_rgb), 32'h00FF_00FF);
        @(posedge clk); #1;

        // Stall the output for five cycles and poke an input that must be dropped.
        output_ready = 1'b0;
        applyStimulus(96'd0, {3{32'h0000_8000}}, 1'b1);
        wait_valid("bp");
        checkOutput("bp_pixel", 32'(pixel_rgb), 32'(EXP_HALF));
        for (int i = 0; i < 5; i++) begin
            if (i == 2)
                applyStimulus(96'd0, {3{32'h0000_F000}}, 1'b1);
            else begin
                @(posedge clk); #1;
            end
            checkOutput("bp_hold_valid", 32'(output_valid), 32'd1);
            checkOutput("bp_hold_pixel", 32'(pixel_rgb), 32'(EXP_HALF));
            checkOutput("bp_hold_inready", 32'(in_ready), 32'd0);
        end
        checkOutput("bp_overflow", 32'(overflow_err), 32'd1);
        output_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_valid", 32'(output_valid), 32'd0);
        checkOutput("bp_release_inready", 32'(in_ready), 32'd1);
        run_single("after_bp");

        checkOutput("count_err_clear", 32'(count_err), 32'd0);
        dif_q.delete();
        for (int i = 0; i < 8; i++) begin
            dif_q.push_back({32'h0000_1000, 64'd0});
            applyStimulus(96'd0, {32'h0000_1000, 64'd0}, 1'b0);
            if (i == 6)
                checkOutput("count_err_early", 32'(count_err), 32'd0);
        end
        checkOutput("count_err_set", 32'(count_err), 32'd1);
        checkOutput("count_close_valid0", 32'(output_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("count_close_valid1", 32'(output_valid), 32'd1);
        checkOutput("count_close_pixel", 32'(pixel_rgb), 32'(model_pixel(96'd0)));
        @(posedge clk); #1;
        dif_q.delete();
        dif_q.push_back({64'd0, 32'h0000_8000});
        applyStimulus(96'd0, {64'd0, 32'h0000_8000}, 1'b1);
        wait_valid("ninth");
        checkOutput("ninth_pixel", 32'(pixel_rgb), 32'(model_pixel(96'd0)));
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an accumulation.
        applyStimulus({3{32'h0000_2000}}, {3{32'h0000_2000}}, 1'b0);
        applyStimulus({3{32'h0000_2000}}, {3{32'h0000_2000}}, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_inready", 32'(in_ready), 32'd1);
        checkOutput("arst_outputs", {7'd0, output_valid, pixel_rgb}, 32'd0);
        checkOutput("arst_flags", {30'd0, overflow_err, count_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_single("after_arst");

        output_ready = 1'b0;
        for (int p = 0; p < 30; p++) begin
            n    = $urandom_range(1, 8);
            amb  = {rnd_ch(), rnd_ch(), rnd_ch()};
            dif_q.delete();
            for (int i = 0; i < n; i++) begin
                dif  = {rnd_ch(), rnd_ch(), rnd_ch()};
                last = (i == n - 1) && ((n < 8) || ($urandom_range(0, 1) == 1));
                dif_q.push_back(dif);
                applyStimulus(amb, dif, last);
                if (i < n - 1)
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            exp_px = model_pixel(amb);
            wait_valid("rand");
            checkOutput("rand_pixel", 32'(pixel_rgb), 32'(exp_px));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                checkOutput("rand_hold", 32'(pixel_rgb), 32'(exp_px));
            end
            output_ready = 1'b1;
            @(posedge clk); #1;
            checkOutput("rand_release", 32'(output_valid), 32'd0);
            output_ready = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
